ram_kdw_bank: RTL
=================

RAM_KDW_BANK -- requirements
Module: ram_kdw_bank

Interface
REQ-001 Parameter N_BANK, default 4, number of independent weight banks.
REQ-002 Parameter DEPTH, default KDW_N_ELEM, words per bank.
REQ-003 Parameter DW, default WG_W, word width in bits.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-009 req_op  in  2  kdw_op_t: READ=0, WRITE=1, ACC=2; 3 illegal.
REQ-010 req_bank  in  $clog2(N_BANK)  target bank.
REQ-011 req_addr  in  $clog2(DEPTH)  word address in bank.
REQ-012 req_data  in  DW  write data or accumulate addend.
REQ-013 rd_valid  out  1  one-cycle pulse per accepted request.
REQ-014 rd_data  out  DW  response word.
REQ-015 rd_err  out  1  qualifies rd_valid: request was illegal.
REQ-016 clr_start  in  1  pulse: zero all banks.
REQ-017 clr_busy  out  1  high while drain/clear in progress.

Function
REQ-018 Accepted request SHALL traverse 2 stages (S1 read, S2 modify/write); rd_valid/rd_data SHALL assert exactly 2 cycles after acceptance; one request per cycle sustained.
REQ-019 READ SHALL return the word including effects of every earlier accepted request (S2->S1 same bank/address forwarding, no stall).
REQ-020 WRITE SHALL commit req_data at S2 and return req_data (write-through).
REQ-021 ACC SHALL commit and return (old + req_data) mod 2^DW; back-to-back ACC to same bank/address SHALL chain without loss.
REQ-022 Requests to different banks SHALL not interact; forwarding compares bank and address.
REQ-023 Illegal request (req_op=3, req_addr>=DEPTH, or req_bank>=N_BANK) SHALL not modify memory and SHALL return rd_valid=1, rd_err=1, rd_data=0 with normal latency.
REQ-024 FSM states IDLE, DRAIN, CLEAR; req_ready = (state==IDLE); clr_busy = (state!=IDLE).
REQ-025 IDLE + clr_start -> DRAIN if S1 or S2 occupied, else CLEAR; req_valid in that same cycle SHALL not be accepted.
REQ-026 DRAIN: in-flight requests complete normally; -> CLEAR when S1 and S2 empty.
REQ-027 CLEAR: write 0 to address c in all banks each cycle, c = 0..DEPTH-1; -> IDLE after c=DEPTH-1 (exactly DEPTH cycles); clr_start in DRAIN/CLEAR ignored.
REQ-028 rd_valid SHALL be 0 in every cycle without a completing request; rd_data SHALL hold its last value otherwise.

Reset
REQ-029 rst_n low SHALL immediately force: state=CLEAR, c=0, S1/S2 empty, rd_valid=0, rd_err=0, rd_data=0, clr_busy=1, req_ready=0.
REQ-030 Memory arrays SHALL not be reset; the post-reset CLEAR sweep zeroes them; rst_n mid-operation drops in-flight requests without response.

Structure
REQ-031 ram_pkg SHALL hold kdw_op_t, KDW_N_ELEM, WG_W and default N_BANK.
REQ-032 One sub-module kdw_bank_sram (1 write, 1 sync read, 1-cycle, no reset) SHALL be instantiated N_BANK times via generate.

Verification (N_BANK=4, DEPTH=16, DW=8)
REQ-033 Release reset -> clr_busy high exactly 16 cycles, then READ any bank/addr returns 0x00.
REQ-034 WRITE b1 a3 0x5A, READ b1 a3 next cycle -> responses 0x5A, 0x5A on consecutive cycles.
REQ-035 ACC b2 a7 +0xF0 then +0x20 back-to-back from 0 -> responses 0xF0, 0x10 (wrap); memory 0x10.
REQ-036 WRITE b0 a5 0x11 then READ b3 a5 -> second response 0x00 (bank isolation).
REQ-037 READ addr 20 and op=3 -> rd_valid=1, rd_err=1, rd_data=0x00, memory unchanged.
REQ-038 clr_start with two requests in flight -> both respond correctly, req_ready low, then 16-cycle CLEAR, all words 0x00.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and defaults for the KDW weight-bank RAM.
//   kdw_op_t     request opcode (READ, WRITE, ACC; value 3 is illegal)
//   kdw_state_t  control FSM states of ram_kdw_bank
//   KDW_N_ELEM   default words per bank
//   WG_W         default word width in bits
//   KDW_N_BANK   default number of banks
package ram_pkg;

    typedef enum logic [1:0] {
        KdwRead  = 2'd0,
        KdwWrite = 2'd1,
        KdwAcc   = 2'd2,
        KdwIll   = 2'd3
    } kdw_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StClear
    } kdw_state_t;

    localparam int unsigned KDW_N_ELEM = 16;
    localparam int unsigned WG_W       = 8;
    localparam int unsigned KDW_N_BANK = 4;

endpackage

// File: rtl/kdw_bank_sram.sv
// kdw_bank_sram: one weight bank, 1 write port + 1 synchronous read port.
//   clk    clock
//   we     write enable, waddr/wdata committed on the rising edge
//   raddr  read address, rdata valid the cycle after (old data on collision)
// Contents are not reset.
module kdw_bank_sram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_kdw_bank.sv
// ram_kdw_bank: N_BANK independent weight banks behind a 2-stage
// read / modify-write pipeline, with a drain-then-clear sweep.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_op/bank/addr/data request fields (READ, WRITE, ACC)
//   rd_valid/rd_data      one response per accepted request, 2 cycles later
//   rd_err                response belongs to an illegal request
//   clr_start, clr_busy   start a full zero sweep / sweep (or drain) active
module ram_kdw_bank import ram_pkg::*; #(
    parameter int unsigned N_BANK = KDW_N_BANK,
    parameter int unsigned DEPTH  = KDW_N_ELEM,
    parameter int unsigned DW     = WG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [$clog2(N_BANK)-1:0] req_bank,
    input  logic [$clog2(DEPTH)-1:0]  req_addr,
    input  logic [DW-1:0]             req_data,
    output logic                      rd_valid,
    output logic [DW-1:0]             rd_data,
    output logic                      rd_err,
    input  logic                      clr_start,
    output logic                      clr_busy
);

    localparam int unsigned BW = $clog2(N_BANK);
    localparam int unsigned AW = $clog2(DEPTH);

    kdw_state_t    state;
    logic [AW-1:0] clr_cnt;

    // S1: request captured at acceptance, bank read data arrives this stage.
    logic          s1_valid;
    logic          s1_err;
    kdw_op_t       s1_op;
    logic [BW-1:0] s1_bank;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_data;

    // S2: response stage; memory is written as a request moves S1 -> S2.
    logic          s2_we;
    logic [BW-1:0] s2_bank;
    logic [AW-1:0] s2_addr;

    logic          req_legal;
    logic          accept;
    logic          clearing;
    logic          fwd_hit;
    logic          s1_we;
    logic [DW-1:0] old_word;
    logic [DW-1:0] s1_result;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] bank_rdata [N_BANK];
    logic [N_BANK-1:0] bank_we;

    // Widen before comparing so out-of-range checks stay meaningful for any size.
    assign req_legal = (req_op != 2'd3) && (32'(req_addr) < DEPTH) && (32'(req_bank) < N_BANK);
    assign req_ready = (state == StIdle);
    assign clr_busy  = (state != StIdle);
    // A request colliding with clr_start is refused even though ready is high.
    assign accept    = req_valid && req_ready && !clr_start;
    assign clearing  = (state == StClear);

    always_comb begin
        // The S2 entry wrote memory on the same edge S1 issued its read, so the
        // read returned the pre-write word; take S2's result instead.
        fwd_hit  = rd_valid && s2_we && (s2_bank == s1_bank) && (s2_addr == s1_addr);
        old_word = fwd_hit ? rd_data : bank_rdata[s1_bank];
        unique case (s1_op)
            KdwWrite: s1_result = s1_data;
            KdwAcc:   s1_result = old_word + s1_data;
            default:  s1_result = old_word;
        endcase
        s1_we   = s1_valid && !s1_err && (s1_op == KdwWrite || s1_op == KdwAcc);
        wr_addr = clearing ? clr_cnt : s1_addr;
        wr_data = clearing ? '0 : s1_result;
    end

    for (genvar b = 0; b < N_BANK; b++) begin : g_bank
        assign bank_we[b] = clearing || (s1_we && (s1_bank == BW'(b)));

        kdw_bank_sram #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_sram (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_addr),
            .wdata (wr_data),
            .raddr (req_addr),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_op    <= KdwRead;
            s1_bank  <= '0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s2_we    <= 1'b0;
            s2_bank  <= '0;
            s2_addr  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err  <= !req_legal;
                s1_op   <= kdw_op_t'(req_op);
                s1_bank <= req_bank;
                s1_addr <= req_addr;
                s1_data <= req_data;
            end
            rd_valid <= s1_valid;
            rd_err   <= s1_valid && s1_err;
            s2_we    <= s1_we;
            if (s1_valid) begin
                rd_data <= s1_err ? '0 : s1_result;
                s2_bank <= s1_bank;
                s2_addr <= s1_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StClear;
            clr_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (clr_start) begin
                        state <= (s1_valid || rd_valid) ? StDrain : StClear;
                    end
                    clr_cnt <= '0;
                end
                StDrain: begin
                    if (!s1_valid && !rd_valid) begin
                        state <= StClear;
                    end
                end
                StClear: begin
                    if (32'(clr_cnt) == DEPTH - 1) begin
                        state   <= StIdle;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
